// File: rtl/demux_pkg.sv
// Shared definitions for the 1:4 stream demultiplexer: channel count, select type
// and select-to-mask decode.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // One-hot channel mask: 00->ch0, 01->ch1, 10->ch2, 11->ch3.
    function automatic logic [NUM_CH-1:0] ch_onehot(input ch_sel_t sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO with wrap-bit pointers. The head entry is presented directly
// from storage, so there is no path from push data to the head output.
module demux_chan_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic              empty,
    output logic [DATA_W-1:0] head_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("demux_chan_fifo: DEPTH must be a power of two, at least 2");
        end
    endgenerate

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push_en;
    logic              pop_en;

    // Same address with differing wrap bits means every slot is occupied.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop_en) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/demux_stream_router.sv
// Registered 1:4 stream demultiplexer: routes each accepted beat into the FIFO of
// the channel named by in_sel and keeps a saturating accepted-beat count per channel.
module demux_stream_router
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [SEL_W-1:0]           in_sel,
    output logic [NUM_CH-1:0]          out_valid,
    input  logic [NUM_CH-1:0]          out_ready,
    output logic [NUM_CH*DATA_W-1:0]   out_data,
    output logic [NUM_CH*CNT_W-1:0]    beat_cnt,
    input  logic                       cnt_clr
);

    logic [NUM_CH-1:0] ch_full;
    logic [NUM_CH-1:0] ch_empty;
    logic [NUM_CH-1:0] push_vec;
    logic [NUM_CH-1:0] pop_vec;
    logic [DATA_W-1:0] ch_head [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic              accept;

    // Head-of-line blocking: only the selected channel's fullness gates the input.
    assign in_ready = ~ch_full[in_sel];
    assign accept   = in_valid && in_ready;
    assign push_vec = accept ? ch_onehot(ch_sel_t'(in_sel)) : '0;
    assign pop_vec  = ~ch_empty & out_ready;

    assign out_valid = ~ch_empty;

    generate
        for (genvar n = 0; n < int'(NUM_CH); n++) begin : g_ch
            demux_chan_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push_vec[n]),
                .push_data (in_data),
                .full      (ch_full[n]),
                .pop       (pop_vec[n]),
                .empty     (ch_empty[n]),
                .head_data (ch_head[n])
            );

            // Clear wins over a same-cycle accept; the count sticks at all-ones.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q[n] <= '0;
                end else if (cnt_clr) begin
                    cnt_q[n] <= '0;
                end else if (push_vec[n] && (cnt_q[n] != '1)) begin
                    cnt_q[n] <= cnt_q[n] + CNT_W'(1);
                end
            end

            assign out_data[n*DATA_W +: DATA_W] = ch_head[n];
            assign beat_cnt[n*CNT_W +: CNT_W]   = cnt_q[n];
        end
    endgenerate

endmodule

// File: tb/tb_demux_stream_router.sv
// Scoreboard bench for demux_stream_router: per-channel expected-beat queues,
// occupancy-derived ready/valid expectations and a saturating counter model.
module tb_demux_stream_router;
    import demux_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic                      clk;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic [SEL_W-1:0]          in_sel;
    logic [NUM_CH-1:0]         out_valid;
    logic [NUM_CH-1:0]         out_ready;
    logic [NUM_CH*DATA_W-1:0]  out_data;
    logic [NUM_CH*CNT_W-1:0]   beat_cnt;
    logic                      cnt_clr;

    int vectors;
    int miscompares;

    logic [DATA_W-1:0] sbq [NUM_CH][$];
    int unsigned       cnt_m [NUM_CH];

    demux_stream_router #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_cnt  (beat_cnt),
        .cnt_clr   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge rst_n) begin
        for (int n = 0; n < int'(NUM_CH); n++) begin
            sbq[n].delete();
            cnt_m[n] = 0;
        end
    end

    // Inputs change just after posedge, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        logic                      exp_rdy;
        logic [NUM_CH*CNT_W-1:0]   exp_cnt;
        logic [NUM_CH-1:0]         mask;
        if (rst_n) begin
            exp_rdy = (sbq[in_sel].size() < int'(DEPTH));
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL mon_in_ready sel=%0d got=%b exp=%b t=%0t", in_sel, in_ready, exp_rdy, $time);
            end
            for (int n = 0; n < int'(NUM_CH); n++) begin
                vectors++;
                if (out_valid[n] !== (sbq[n].size() != 0)) begin
                    miscompares++;
                    $display("FAIL mon_out_valid ch=%0d got=%b exp=%b t=%0t", n, out_valid[n], sbq[n].size() != 0, $time);
                end
                if (sbq[n].size() != 0) begin
                    vectors++;
                    if (out_data[n*DATA_W +: DATA_W] !== sbq[n][0]) begin
                        miscompares++;
                        $display("FAIL mon_out_data ch=%0d got=%h exp=%h t=%0t", n, out_data[n*DATA_W +: DATA_W], sbq[n][0], $time);
                    end
                end
            end
            for (int n = 0; n < int'(NUM_CH); n++) exp_cnt[n*CNT_W +: CNT_W] = CNT_W'(cnt_m[n]);
            vectors++;
            if (beat_cnt !== exp_cnt) begin
                miscompares++;
                $display("FAIL mon_beat_cnt got=%h exp=%h t=%0t", beat_cnt, exp_cnt, $time);
            end
            // Model update for the coming edge.
            for (int n = 0; n < int'(NUM_CH); n++) begin
                if (sbq[n].size() != 0 && out_ready[n]) void'(sbq[n].pop_front());
            end
            mask = ch_onehot(ch_sel_t'(in_sel));
            for (int n = 0; n < int'(NUM_CH); n++) begin
                if (in_valid && exp_rdy && mask[n]) begin
                    sbq[n].push_back(in_data);
                    if (!cnt_clr && cnt_m[n] < CNT_MAX) cnt_m[n]++;
                end
                if (cnt_clr) cnt_m[n] = 0;
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s, input logic clr);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        cnt_clr  = clr;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                cnt_clr  = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout data=%h sel=%0d got=in_ready_low exp=accept", d, s);
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 4'b0000 || beat_cnt !== '0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b/%h/%h exp=0000/0/0", out_valid, beat_cnt, out_data);
        end
        #1 rst_n = 1'b1;
        for (int s = 0; s < int'(NUM_CH); s++) begin
            in_sel = SEL_W'(s);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_in_ready sel=%0d got=%b exp=1", s, in_ready);
            end
        end
        idle(1);
    endtask

    task automatic test_basic_routing;
        out_ready = 4'b1111;
        for (int s = 0; s < int'(NUM_CH); s++) send(8'hA0 + DATA_W'(s), SEL_W'(s), 1'b0);
        idle(2);
        @(negedge clk);
        vectors++;
        if (beat_cnt !== 16'h1111) begin
            miscompares++;
            $display("FAIL basic_beat_cnt got=%h exp=1111", beat_cnt);
        end
        idle(1);
    endtask

    task automatic test_full_backpressure;
        out_ready = 4'b1011;
        send(8'hC0, 2'd2, 1'b0);
        send(8'hC1, 2'd2, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hC2;
        in_sel   = 2'd2;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_data[2*DATA_W +: DATA_W] !== 8'hC0) begin
                miscompares++;
                $display("FAIL full_stall got=%b/%h exp=0/c0", in_ready, out_data[2*DATA_W +: DATA_W]);
            end
        end
        @(posedge clk);
        #1 out_ready[2] = 1'b1;
        @(posedge clk);
        #1 out_ready[2] = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_release got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 4'b1111;
        idle(4);
    endtask

    task automatic test_push_pop;
        out_ready = 4'b1101;
        send(8'h11, 2'd1, 1'b0);
        out_ready[1] = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_sel   = 2'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready[1] = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid[1] !== 1'b1 || out_data[DATA_W +: DATA_W] !== 8'h55 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL push_pop_occupancy got=%b/%h/%b exp=1/55/1", out_valid[1], out_data[DATA_W +: DATA_W], in_ready);
        end
        out_ready = 4'b1111;
        idle(3);
    endtask

    task automatic test_counter;
        out_ready = 4'b1111;
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++) send(DATA_W'(i), 2'd0, 1'b0);
        @(negedge clk);
        vectors++;
        if (beat_cnt[0 +: CNT_W] !== 4'd15) begin
            miscompares++;
            $display("FAIL cnt_saturate got=%0d exp=15", beat_cnt[0 +: CNT_W]);
        end
        send(8'hEE, 2'd0, 1'b1);
        @(negedge clk);
        vectors++;
        if (beat_cnt !== '0) begin
            miscompares++;
            $display("FAIL cnt_clear got=%h exp=0", beat_cnt);
        end
        idle(2);
    endtask

    task automatic test_reset_mid;
        out_ready = 4'b0111;
        send(8'hD0, 2'd3, 1'b0);
        send(8'hD1, 2'd3, 1'b0);
        in_sel = 2'd3;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_full got=%b exp=0", in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid[3] !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL mid_async_clear got=%b/%h exp=0/0", out_valid[3], out_data);
        end
        idle(2);
        in_valid = 1'b1;
        in_data  = 8'hF3;
        in_sel   = 2'd3;
        #1 rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_after_release got=%b/%b exp=1/0000", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid[3] !== 1'b1 || out_data[3*DATA_W +: DATA_W] !== 8'hF3) begin
            miscompares++;
            $display("FAIL mid_first_accept got=%b/%h exp=1/f3", out_valid[3], out_data[3*DATA_W +: DATA_W]);
        end
        out_ready = 4'b1111;
        idle(3);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_sel      = '0;
        out_ready   = '0;
        cnt_clr     = 1'b0;
        test_reset();
        test_basic_routing();
        test_full_backpressure();
        test_push_pop();
        test_counter();
        test_reset_mid();
        for (int n = 0; n < int'(NUM_CH); n++) begin
            vectors++;
            if (sbq[n].size() != 0) begin
                miscompares++;
                $display("FAIL drain ch=%0d got=%0d_left exp=0", n, sbq[n].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
